// File: rtl/mod_adder_scheduler.sv
// -----------------------------------------------------------------------------
// mod_adder_scheduler
//
// Round-robin front end that time-shares one external combinational
// modulo-(2^n-k) adder among NUM_REQ requesters. One operation is in flight at
// a time: the winner's operands are registered onto the adder and held for
// SETTLE_CYCLES edges. The sum is then captured and returned with the
// requester index on a valid/ready response channel.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset
//   req_valid[i]        requester i has an operation pending
//   req_ready[i]        grant to requester i (one-hot or zero, IDLE only)
//   req_a/b/k           packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/b/k           registered operands driven onto the shared adder
//   add_sum             sum returned by the shared adder
//   resp_valid/ready    response handshake
//   resp_sum, resp_id   captured sum and index of the served requester
//   busy                high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module mod_adder_scheduler #(
  parameter int WIDTH         = 7,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*WIDTH-1:0]   req_k,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic [WIDTH-1:0]           add_k,
  input  logic [WIDTH-1:0]           add_sum,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_sum,
  output logic [ID_W-1:0]            resp_id,
  output logic                       busy
);

  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [WIDTH-1:0]   r_add_k;
  logic               r_resp_valid;
  logic [WIDTH-1:0]   r_resp_sum;
  logic [ID_W-1:0]    r_resp_id;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic               w_capture;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [WIDTH-1:0]   w_sel_k;

  // (base + off) mod NUM_REQ, for base < NUM_REQ and off <= NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: the first valid requester at or after r_rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, off)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_rr_ptr, off);
      end
    end
  end

  assign w_sel_a = req_a[int'(w_win)*WIDTH +: WIDTH];
  assign w_sel_b = req_b[int'(w_win)*WIDTH +: WIDTH];
  assign w_sel_k = req_k[int'(w_win)*WIDTH +: WIDTH];

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        // The grant only goes to a valid requester, so a grant is an acceptance.
        if (w_found) begin
          w_ready[w_win] = 1'b1;
          w_accept       = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cnt == CNT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // No grant may be visible while reset is applied.
    if (rst) begin
      w_ready  = '0;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_cnt        <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_k      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_sum   <= '0;
      r_resp_id    <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Operands are latched once at acceptance and held until the next grant,
      // so later changes on req_a/b/k cannot disturb the operation in flight.
      if (w_accept) begin
        r_add_a   <= w_sel_a;
        r_add_b   <= w_sel_b;
        r_add_k   <= w_sel_k;
        r_resp_id <= w_win;
        r_rr_ptr  <= wrap_add(w_win, 1);
        r_cnt     <= '0;
      end else if (r_state == S_ISSUE && !w_capture) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_capture) begin
        r_resp_sum   <= add_sum;
        r_resp_valid <= 1'b1;
      end else if (r_state == S_RESP && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign req_ready  = w_ready;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_k      = r_add_k;
  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != S_IDLE);

endmodule
